// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: requester ids,
// FSM state encodings, access counter width and the ack decode helper.
package mem_port_arbiter_pkg;

    // Access counter must hold MEM_LAT-1 for the legal range 1..15.
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACK_W = 3;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_DATA  = 2'd1,
        REQ_DEBUG = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // One-hot ack vector {debug, data, fetch} for a grant id.
    function automatic logic [ACK_W-1:0] ack_onehot(input req_id_e id);
        logic [ACK_W-1:0] v;
        v = '0;
        case (id)
            REQ_FETCH: v = 3'b001;
            REQ_DATA:  v = 3'b010;
            REQ_DEBUG: v = 3'b100;
            default:   v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational grant picker: debug has absolute priority, fetch and data
// share a two-way round robin where the requester not named by rr_ptr wins
// a tie.
// Ports:
//   f_req, d_req, g_req : request lines
//   rr_ptr              : last served fetch/data requester
//   grant_c             : winning requester id
//   grant_vld_c         : at least one request is pending
module mem_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic    f_req,
    input  logic    d_req,
    input  logic    g_req,
    input  req_id_e rr_ptr,
    output req_id_e grant_c,
    output logic    grant_vld_c
);

    always_comb begin
        grant_c     = REQ_FETCH;
        grant_vld_c = f_req | d_req | g_req;
        if (g_req) begin
            grant_c = REQ_DEBUG;
        end else if (f_req && d_req) begin
            grant_c = (rr_ptr == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
        end else if (d_req) begin
            grant_c = REQ_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between instruction fetch, data access
// and the debug/loader port. One transaction at a time: IDLE arbitrates and
// latches operands, ACCESS holds mem_en for MEM_LAT cycles, DONE pulses the
// matching ack. All outputs are registered.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   f_req/f_addr/f_ack                 : fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata/d_ack    : data requester
//   g_req/g_we/g_addr/g_wdata/g_ack    : debug/loader requester
//   rdata                              : last read word, valid in ack cycle
//   busy                               : FSM not idle
//   mem_en/mem_we/mem_addr/mem_wdata   : memory macro control
//   mem_rdata                          : memory read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            state_q;
    state_e            state_d;
    req_id_e           grant_q;
    req_id_e           rr_ptr_q;
    req_id_e           pick_id_c;
    logic              pick_vld_c;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              acc_we_c;
    logic              grant_now_c;
    logic              last_beat_c;

    mem_rr_pick u_pick (
        .f_req       (f_req),
        .d_req       (d_req),
        .g_req       (g_req),
        .rr_ptr      (rr_ptr_q),
        .grant_c     (pick_id_c),
        .grant_vld_c (pick_vld_c)
    );

    // Operand mux for the winner and next-state decode.
    always_comb begin
        state_d     = state_q;
        sel_we_c    = 1'b0;
        sel_addr_c  = f_addr;
        sel_wdata_c = '0;
        grant_now_c = (state_q == ST_IDLE) && pick_vld_c;
        last_beat_c = (state_q == ST_ACCESS) && (cnt_q == '0);

        case (pick_id_c)
            REQ_DATA: begin
                sel_we_c    = d_we;
                sel_addr_c  = d_addr;
                sel_wdata_c = d_wdata;
            end
            REQ_DEBUG: begin
                sel_we_c    = g_we;
                sel_addr_c  = g_addr;
                sel_wdata_c = g_wdata;
            end
            default: begin
                sel_we_c    = 1'b0;
                sel_addr_c  = f_addr;
                sel_wdata_c = '0;
            end
        endcase

        case (state_q)
            ST_IDLE:   if (pick_vld_c) state_d = ST_ACCESS;
            ST_ACCESS: if (last_beat_c) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Write enable seen by the memory during the coming ACCESS cycle.
        acc_we_c = (state_q == ST_IDLE) ? sel_we_c : we_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction latch, access counter, read capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= REQ_FETCH;
            rr_ptr_q  <= REQ_FETCH;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (grant_now_c) begin
                grant_q   <= pick_id_c;
                we_q      <= sel_we_c;
                mem_addr  <= sel_addr_c;
                mem_wdata <= sel_wdata_c;
                cnt_q     <= CNT_LOAD;
            end else if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (last_beat_c && !we_q) begin
                rdata <= mem_rdata;
            end

            // Debug grants do not disturb the fetch/data alternation.
            if ((state_q == ST_DONE) && (grant_q != REQ_DEBUG)) begin
                rr_ptr_q <= grant_q;
            end
        end
    end

    // Registered control outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en                <= 1'b0;
            mem_we                <= 1'b0;
            busy                  <= 1'b0;
            {g_ack, d_ack, f_ack} <= '0;
        end else begin
            mem_en                <= (state_d == ST_ACCESS);
            mem_we                <= (state_d == ST_ACCESS) && acc_we_c;
            busy                  <= (state_d != ST_IDLE);
            {g_ack, d_ack, f_ack} <= (state_d == ST_DONE) ? ack_onehot(grant_q) : ACK_W'(0);
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between three requesters: instruction fetch, data access (load/store microinstructions) and the debug/program-loader port.
- Serialises their accesses, sequences the multi-cycle memory timing, and returns read data with a one-cycle ack pulse per transaction.
- Sits between ctrl_unit-driven datapath signals and the memory macro.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width
- MEM_LAT, 2, cycles mem_en is held per access; legal range 1..15

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request (read only)
- f_addr  in  ADDR_W  fetch address
- f_ack  out  1  fetch transaction complete, one-cycle pulse
- d_req  in  1  data request
- d_we  in  1  data write enable (1 = store)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_ack  out  1  data transaction complete, one-cycle pulse
- g_req  in  1  debug/loader request
- g_we  in  1  debug write enable
- g_addr  in  ADDR_W  debug address
- g_wdata  in  DATA_W  debug write value
- g_ack  out  1  debug transaction complete, one-cycle pulse
- rdata  out  DATA_W  registered read data, valid in the ack cycle, held until the next capture
- busy  out  1  high whenever state != IDLE
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on the last ACCESS cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; all outputs 0; rdata 0; rr_ptr = FETCH.
  - Any in-flight access is aborted: mem_en drops immediately and no ack is issued.
- Three states: IDLE, ACCESS, DONE.
- IDLE: at a rising edge with any request high, arbitrate:
  - g_req has absolute priority.
  - Otherwise, if both f_req and d_req are high, the requester other than rr_ptr wins.
  - If only one is high, it wins.
  - Latch grant id, address and we (fetch: we = 0) and wdata into registers; load cnt = MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the latched registers and are stable for all MEM_LAT cycles.
  - cnt decrements each edge.
  - At the edge where cnt == 0: capture mem_rdata into rdata if it is a read (rdata unchanged on writes); go to DONE.
- DONE:
  - Exactly one of f_ack/d_ack/g_ack is high, matching the latched grant.
  - mem_en = 0. Next edge: IDLE.
  - If the grant was fetch or data, rr_ptr is set to that requester at this edge; debug grants leave rr_ptr unchanged.
- Latency:
  - Request sampled at edge E0 → ack high during the cycle after edge E0+MEM_LAT.
  - Minimum request-to-request spacing is MEM_LAT+2 cycles; the one-cycle IDLE bubble is intentional.
- Handshake:
  - The requester holds req and its operands until ack.
  - A req still high in the ack cycle is treated as a new request and is sampled in the following IDLE cycle.
  - Operands may change after the grant edge without effect, since they are latched.
  - If req drops before ack, the transaction still completes and ack still pulses; the requester ignores it.
- Simultaneous events:
  - All three requesting → debug served.
  - Debug held continuously starves fetch and data; this is intended for loader/halt use.
  - f and d alternate strictly while both are held.
- Outputs are registered or decoded from state only; there is no combinational path from req to mem_* or ack.

Decomposition:
- Shared constants file (alongside constants.v):
  - requester ids REQ_FETCH = 2'd0, REQ_DATA = 2'd1, REQ_DEBUG = 2'd2
  - state encodings ST_IDLE/ST_ACCESS/ST_DONE
- One natural sub-module: mem_rr_pick, the combinational two-way round-robin plus debug-priority picker. Inputs: requests and rr_ptr. Output: grant id plus valid.
- The FSM, counter and registers stay in the top.

Test Plan:
- After reset, f_req=1 with f_addr=8'h10, mem_rdata=16'hBEEF, MEM_LAT=2:
  - mem_en high for exactly 2 cycles with mem_addr=8'h10, mem_we=0.
  - f_ack pulses once; rdata=16'hBEEF in the ack cycle.
- Store d_we=1, d_addr=8'h20, d_wdata=16'h1234: 2 cycles with mem_we=1, mem_wdata=16'h1234, then d_ack; rdata keeps its previous value.
- Round robin: hold f_req and d_req high for 4 transactions.
  - Grant order after reset: data, fetch, data, fetch.
  - Ack cycles spaced exactly MEM_LAT+2 = 4 cycles apart.
- Priority: f_req, d_req and g_req all raised together, then g_req dropped after its ack.
  - Debug served first; then data, since rr_ptr is still FETCH; then fetch.
- Reset mid-access: drop rst_n in the 1st ACCESS cycle of a store.
  - mem_en and mem_we go low asynchronously; no d_ack; busy=0.
  - After release, a new f_req completes normally.
- MEM_LAT=1 build with f_req held high for 3 transactions: mem_en is 1 cycle wide, and acks are 3 cycles apart.
